// File: rtl/spi_slave_rx.sv
// -----------------------------------------------------------------------------
// spi_slave_rx
//   SPI mode-0 slave endpoint. LOAD, SCLK and MOSI are oversampled on the
//   system clock through SYNC-deep synchronisers, so no logic runs on SCLK.
//   Each frame receives an M-bit word MSB first on MOSI and returns the word
//   captured from DI at frame start on MISO, also MSB first.
//
// Parameters
//   M     word length in bits (1..255)
//   SYNC  synchroniser depth for LOAD/SCLK/MOSI (>= 2)
//
// Ports
//   clk        in   system clock, all state on rising edge
//   clr_n      in   asynchronous active-low reset
//   LOAD       in   frame select, 1 = idle, 0 = frame active
//   SCLK       in   serial clock from master, idle low
//   MOSI       in   serial data master -> slave
//   DI[M]      in   word returned to master, captured at frame start
//   MISO       out  serial data slave -> master
//   DO[M]      out  last complete received word
//   rx_valid   out  1-cycle pulse when DO is updated
//   busy       out  high while a frame is in progress
//   frame_err  out  1-cycle pulse when a frame ends short of M bits
//   cb_bit[8]  out  received-bit counter (debug)
// -----------------------------------------------------------------------------
module spi_slave_rx #(
  parameter int M    = 16,
  parameter int SYNC = 2
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         LOAD,
  input  logic         SCLK,
  input  logic         MOSI,
  input  logic [M-1:0] DI,
  output logic         MISO,
  output logic [M-1:0] DO,
  output logic         rx_valid,
  output logic         busy,
  output logic         frame_err,
  output logic [7:0]   cb_bit
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [7:0] M_CNT = 8'(M);

  state_t          r_state;
  logic [SYNC-1:0] r_load_sync;
  logic [SYNC-1:0] r_sclk_sync;
  logic [SYNC-1:0] r_mosi_sync;
  logic            r_load_prev;
  logic            r_sclk_prev;
  logic [M-1:0]    r_tx_sr;
  logic [M-1:0]    r_rx_sr;
  logic            r_dlvd;

  logic            w_load_s;
  logic            w_sclk_s;
  logic            w_mosi_s;
  logic            w_load_rise;
  logic            w_load_fall;
  logic            w_sclk_rise;
  logic            w_sclk_fall;
  logic [M-1:0]    w_tx_shift;
  logic [M:0]      w_rx_cat;
  logic [M-1:0]    w_rx_shift;
  logic [7:0]      w_cb_inc;

  assign w_load_s    = r_load_sync[SYNC-1];
  assign w_sclk_s    = r_sclk_sync[SYNC-1];
  assign w_mosi_s    = r_mosi_sync[SYNC-1];
  assign w_load_rise = w_load_s & ~r_load_prev;
  assign w_load_fall = ~w_load_s & r_load_prev;
  assign w_sclk_rise = w_sclk_s & ~r_sclk_prev;
  assign w_sclk_fall = ~w_sclk_s & r_sclk_prev;

  // Shifts written through full-width temporaries so M=1 needs no special case;
  // the MSB of the shifted tx register is the next bit to drive (0 once drained).
  assign w_tx_shift  = r_tx_sr << 1;
  assign w_rx_cat    = {r_rx_sr, w_mosi_s};
  assign w_rx_shift  = w_rx_cat[M-1:0];
  assign w_cb_inc    = cb_bit + 8'd1;

  assign busy        = (r_state != IDLE);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state     <= IDLE;
      r_load_sync <= '1;
      r_sclk_sync <= '0;
      r_mosi_sync <= '0;
      r_load_prev <= 1'b1;
      r_sclk_prev <= 1'b0;
      r_tx_sr     <= '0;
      r_rx_sr     <= '0;
      r_dlvd      <= 1'b0;
      MISO        <= 1'b0;
      DO          <= '0;
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      cb_bit      <= 8'd0;
    end else begin
      r_load_sync <= {r_load_sync[SYNC-2:0], LOAD};
      r_sclk_sync <= {r_sclk_sync[SYNC-2:0], SCLK};
      r_mosi_sync <= {r_mosi_sync[SYNC-2:0], MOSI};
      r_load_prev <= w_load_s;
      r_sclk_prev <= w_sclk_s;
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;

      case (r_state)
        IDLE: begin
          if (w_load_fall) begin
            r_tx_sr <= DI;
            MISO    <= DI[M-1];
            r_rx_sr <= '0;
            cb_bit  <= 8'd0;
            r_dlvd  <= 1'b0;
            r_state <= SHIFT;
          end
        end

        SHIFT: begin
          // LOAD rise takes priority over any SCLK edge seen in the same cycle.
          // Reaching SHIFT with a LOAD rise always means fewer than M bits.
          if (w_load_rise) begin
            frame_err <= 1'b1;
            r_state   <= IDLE;
          end else if (w_sclk_rise) begin
            r_rx_sr <= w_rx_shift;
            cb_bit  <= w_cb_inc;
            if (w_cb_inc == M_CNT) begin
              r_state <= DONE;
            end
          end else if (w_sclk_fall) begin
            r_tx_sr <= w_tx_shift;
            MISO    <= w_tx_shift[M-1];
          end
        end

        DONE: begin
          // SCLK edges are ignored here, so cb_bit stays at M.
          if (!r_dlvd) begin
            DO       <= r_rx_sr;
            rx_valid <= 1'b1;
            r_dlvd   <= 1'b1;
          end
          if (w_load_s) begin
            r_state <= IDLE;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave_rx.sv
// -----------------------------------------------------------------------------
// tb_spi_slave_rx
//   Bench for spi_slave_rx (M=16, SYNC=2). A master task drives frames; full
//   frames push the expected word into a scoreboard queue that a monitor pops
//   on every rx_valid pulse. The word the master captures from MISO is checked
//   against the DI value presented at frame start.
// -----------------------------------------------------------------------------
module tb_spi_slave_rx;

  localparam int M    = 16;
  localparam int SYNC = 2;
  localparam int HALF = 6;   // SCLK half period in clk cycles (>= SYNC+2)

  logic         clk = 1'b0;
  logic         clr_n;
  logic         LOAD;
  logic         SCLK;
  logic         MOSI;
  logic [M-1:0] DI;
  logic         MISO;
  logic [M-1:0] DO;
  logic         rx_valid;
  logic         busy;
  logic         frame_err;
  logic [7:0]   cb_bit;

  int           n_chk   = 0;
  int           n_fail  = 0;
  int           n_valid = 0;
  int           n_err   = 0;
  logic [M-1:0] sb_q[$];

  spi_slave_rx #(.M(M), .SYNC(SYNC)) dut (
    .clk       (clk),
    .clr_n     (clr_n),
    .LOAD      (LOAD),
    .SCLK      (SCLK),
    .MOSI      (MOSI),
    .DI        (DI),
    .MISO      (MISO),
    .DO        (DO),
    .rx_valid  (rx_valid),
    .busy      (busy),
    .frame_err (frame_err),
    .cb_bit    (cb_bit)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard consumer: each rx_valid cycle pops one expected word.
  always @(negedge clk) begin
    if (clr_n === 1'b1 && rx_valid === 1'b1) begin
      n_valid++;
      if (sb_q.size() == 0) begin
        chk("rx_unexpected", 32'd1, 32'd0);
      end else begin
        chk("rx_do", 32'(DO), 32'(sb_q.pop_front()));
      end
    end
    if (clr_n === 1'b1 && frame_err === 1'b1) begin
      n_err++;
    end
  end

  // Drives one frame of npulse SCLK pulses. abort_at > 0 pulses clr_n right
  // after that many pulses and ends the frame there.
  task automatic send_frame(input logic [M-1:0] word, input logic [M-1:0] di_val,
                            input int npulse, input int abort_at, input int gap);
    logic [M-1:0] miso_cap;
    miso_cap = '0;
    if (npulse >= M && abort_at <= 0) sb_q.push_back(word);
    DI   = di_val;
    MOSI = word[M-1];
    LOAD = 1'b0;
    wclk(HALF);
    chk("busy_start", 32'(busy), 32'd1);
    for (int i = 0; i < npulse; i++) begin
      SCLK = 1'b1;
      if (i < M) miso_cap[M-1-i] = MISO;
      wclk(HALF);
      SCLK = 1'b0;
      if (i == 3) DI = ~di_val;   // mid-frame DI change must not matter
      if (i + 1 < M) MOSI = word[M-2-i];
      else           MOSI = 1'b1;
      if (i + 1 == abort_at) begin
        clr_n = 1'b0;
        LOAD  = 1'b1;
        wclk(2);
        chk("abort_do",     32'(DO),        32'd0);
        chk("abort_cb",     32'(cb_bit),    32'd0);
        chk("abort_busy",   32'(busy),      32'd0);
        chk("abort_miso",   32'(MISO),      32'd0);
        chk("abort_rxv",    32'(rx_valid),  32'd0);
        clr_n = 1'b1;
        wclk(HALF);
        return;
      end
      wclk(HALF);
    end
    LOAD = 1'b1;
    wclk(gap);
    if (npulse >= M) chk("miso_word", 32'(miso_cap), 32'(di_val));
  endtask

  initial begin
    clr_n = 1'b0;
    LOAD  = 1'b0;
    SCLK  = 1'b0;
    MOSI  = 1'b0;
    DI    = '0;

    // Reset held with LOAD low and SCLK toggling
    for (int i = 0; i < 8; i++) begin
      SCLK = ~SCLK;
      MOSI = ~MOSI;
      wclk(2);
    end
    chk("rst_do",    32'(DO),        32'd0);
    chk("rst_miso",  32'(MISO),      32'd0);
    chk("rst_busy",  32'(busy),      32'd0);
    chk("rst_rxv",   32'(rx_valid),  32'd0);
    chk("rst_ferr",  32'(frame_err), 32'd0);
    chk("rst_cb",    32'(cb_bit),    32'd0);
    LOAD = 1'b1;
    SCLK = 1'b0;
    MOSI = 1'b0;
    wclk(2);
    clr_n = 1'b1;
    wclk(HALF);
    chk("idle_busy", 32'(busy), 32'd0);

    // Basic frame
    send_frame(16'h3C96, 16'hA5C3, 16, 0, 8);
    chk("t2_busy",  32'(busy),    32'd0);
    chk("t2_valid", 32'(n_valid), 32'd1);
    chk("t2_do",    32'(DO),      32'h3C96);
    chk("t2_err",   32'(n_err),   32'd0);

    // Back-to-back frames with a 4-clk LOAD high gap
    send_frame(16'h0001, 16'h1234, 16, 0, 4);
    send_frame(16'hFFFE, 16'h8001, 16, 0, 8);
    chk("t3_valid", 32'(n_valid), 32'd3);
    chk("t3_do",    32'(DO),      32'hFFFE);

    // Short frame
    send_frame(16'h5A5A, 16'h0000, 9, 0, 8);
    chk("t4_err",   32'(n_err),   32'd1);
    chk("t4_valid", 32'(n_valid), 32'd3);
    chk("t4_do",    32'(DO),      32'hFFFE);
    chk("t4_busy",  32'(busy),    32'd0);

    // Long frame: extra pulses ignored
    send_frame(16'hBEEF, 16'h0F0F, 18, 0, 8);
    chk("t5_valid", 32'(n_valid), 32'd4);
    chk("t5_do",    32'(DO),      32'hBEEF);
    chk("t5_cb",    32'(cb_bit),  32'd16);
    chk("t5_err",   32'(n_err),   32'd1);

    // Reset mid-frame after bit 7, then a clean frame
    send_frame(16'hAAAA, 16'hFFFF, 16, 7, 8);
    chk("t6_valid0", 32'(n_valid), 32'd4);
    send_frame(16'h1234, 16'hC0DE, 16, 0, 8);
    chk("t6_valid", 32'(n_valid), 32'd5);
    chk("t6_do",    32'(DO),      32'h1234);
    chk("t6_err",   32'(n_err),   32'd1);

    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
